// File: rtl/sort_run_sequencer.sv
// Run sequencer: loads N_WORDS into data memory with the core held in reset, runs the core until it
// stores to DONE_ADDR (or MAX_CYCLES expire), then dumps memory. Optional macro: SORT_RESULT_CHECK_EN.
module sort_run_sequencer #(
  parameter int          N_WORDS    = 40,
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] DONE_ADDR  = 32'h3FC,
  parameter int          MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              dump_valid,
  output logic [31:0]       dump_data,
  input  logic              dump_ready,
  output logic              core_rst_n,
  input  logic              core_mem_we,
  input  logic [31:0]       core_mem_addr,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       run_cycles,
  output logic              sort_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP,
    S_FIN
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_WORDS - 1);
  localparam logic [31:0]       LIMIT_CNT = 32'(MAX_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       run_cycles_q, run_cycles_d;
  logic              timeout_q, timeout_d;

  logic start_acc;
  logic load_acc;
  logic dump_xfer;
  logic done_hit;
  logic limit_hit;
  logic at_last;

  assign start_acc = (state_q == S_IDLE) && start;
  assign load_acc  = (state_q == S_LOAD) && load_valid;
  assign dump_xfer = (state_q == S_DUMP) && dump_ready;
  assign done_hit  = core_mem_we && (core_mem_addr == DONE_ADDR);
  assign limit_hit = (run_cycles_q == LIMIT_CNT);
  assign at_last   = (idx_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      run_cycles_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_cycles_q <= run_cycles_d;
      timeout_q    <= timeout_d;
    end
  end

  // NOTE: every comb output gets a default up front so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    run_cycles_d = run_cycles_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d      = S_LOAD;
          idx_d        = '0;
          run_cycles_d = '0;
          timeout_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_acc) begin
          if (at_last) begin
            state_d = S_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 32'd1;
        // A completion store in the limit cycle counts as a normal finish.
        if (done_hit) begin
          state_d = S_DUMP;
        end else if (limit_hit) begin
          state_d   = S_DUMP;
          timeout_d = 1'b1;
        end
      end
      S_DUMP: begin
        if (dump_xfer) begin
          if (at_last) begin
            state_d = S_FIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    dump_valid = 1'b0;
    core_rst_n = 1'b0;
    mem_sel    = 1'b1;
    mem_we     = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid;
      end
      S_RUN: begin
        core_rst_n = 1'b1;
        mem_sel    = 1'b0;
      end
      S_DUMP:  dump_valid = 1'b1;
      S_FIN:   done       = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr   = idx_q;
  assign mem_wd     = load_data;
  assign dump_data  = mem_rd;
  assign timeout    = timeout_q;
  assign run_cycles = run_cycles_q;

`ifdef SORT_RESULT_CHECK_EN
  logic [31:0] prev_q;
  logic        sort_err_q;

  // idx==0 marks the first transfer of a dump, which has no predecessor to compare against.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      sort_err_q <= 1'b0;
    end else if (start_acc) begin
      sort_err_q <= 1'b0;
    end else if (dump_xfer) begin
      prev_q <= mem_rd;
      if ((idx_q != '0) && (mem_rd < prev_q)) sort_err_q <= 1'b1;
    end
  end

  assign sort_err = sort_err_q;
`else
  assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_run_sequencer.sv
// Directed bench for sort_run_sequencer: load/run/dump, stalls, timeout, mid-run reset, sort check.
module tb_sort_run_sequencer;

  localparam int N      = 40;
  localparam int AW     = 10;
  localparam int MAXCYC = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, load_valid, dump_ready, core_mem_we;
  logic [31:0]   load_data, core_mem_addr;
  logic          load_ready, dump_valid, core_rst_n, mem_sel, mem_we;
  logic          busy, done, timeout, sort_err;
  logic [31:0]   dump_data, mem_wd, mem_rd, run_cycles;
  logic [AW-1:0] mem_addr;

  logic [31:0] mem [0:(1<<AW)-1];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc;
  int done_before;

  always #5 clk = ~clk;

  sort_run_sequencer #(
    .N_WORDS(N), .ADDR_W(AW), .DONE_ADDR(32'h3FC), .MAX_CYCLES(MAXCYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
    .core_rst_n(core_rst_n), .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles), .sort_err(sort_err)
  );

  // Data memory: sequencer port when mem_sel=1, core stores otherwise; combinational read.
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_sel && mem_we) mem[mem_addr] <= mem_wd;
    else if (!mem_sel && core_mem_we) mem[core_mem_addr[11:2]] <= 32'h0000_0D0E;
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_val(input int mode, input int k);
    case (mode)
      0: word_val = 32'(k);
      1: word_val = (k == 0) ? 32'd3 : (k == 1) ? 32'd7 : (k == 2) ? 32'd2 : 32'(k);
      default: word_val = 32'(200 + k);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("load_entry_ready", load_ready, 1);
    check("load_entry_busy", busy, 1);
    check("load_entry_addr", mem_addr, 0);
  endtask

  task automatic load_words(input int mode);
    for (int k = 0; k < N; k++) begin
      if (k == 20) begin
        load_valid = 1'b0;
        #1;
        check("load_stall_we", mem_we, 0);
        tick();
        check("load_stall_addr", mem_addr, 20);
      end
      load_valid = 1'b1;
      load_data  = word_val(mode, k);
      #1;
      check("load_we", mem_we, 1);
      check("load_addr", mem_addr, k);
      check("load_core_held", core_rst_n, 0);
      tick();
    end
    load_valid = 1'b0;
    #1;
    check("run_core_rst_n", core_rst_n, 1);
    check("run_mem_sel", mem_sel, 0);
    check("run_mem_we", mem_we, 0);
    check("run_load_ready", load_ready, 0);
    check("run_cycles_start", run_cycles, 0);
  endtask

  task automatic dump_words(input int mode, input bit toggle);
    for (int k = 0; k < N; k++) begin
      if (toggle) begin
        dump_ready = 1'b0;
        #1;
        check("dump_stall_data", dump_data, word_val(mode, k));
        tick();
        check("dump_hold_addr", mem_addr, k);
        check("dump_hold_data", dump_data, word_val(mode, k));
      end
      dump_ready = 1'b1;
      #1;
      check("dump_valid", dump_valid, 1);
      check("dump_data", dump_data, word_val(mode, k));
      if (mode == 1 && k == 2) check("sort_err_before_3rd", sort_err, 0);
      tick();
`ifdef SORT_RESULT_CHECK_EN
      if (mode == 1 && k == 2) check("sort_err_after_3rd", sort_err, 1);
`else
      if (mode == 1 && k == 2) check("sort_err_tied", sort_err, 0);
`endif
    end
    dump_ready = 1'b0;
    #1;
    check("fin_done", done, 1);
    check("fin_busy", busy, 1);
    tick();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_core_rst_n", core_rst_n, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
    dump_ready = 1'b0; core_mem_we = 1'b0; core_mem_addr = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_mem_sel", mem_sel, 1);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_sort_err", sort_err, 0);
    check("rst_strobes", {load_ready, dump_valid, mem_we}, 0);
    check("rst_idx", mem_addr, 0);
    rst = 1'b0;
    tick();

    // Load ascending words, run, finish via done store, dump with toggling ready.
    do_start();
    load_words(0);
    core_mem_we = 1'b1; core_mem_addr = 32'h3F8;
    tick();
    core_mem_we = 1'b0;
    #1;
    check("non_done_store_stays_run", core_rst_n, 1);
    tick();
    tick();
    check("run_cycles_3", run_cycles, 3);
    core_mem_we = 1'b1; core_mem_addr = 32'h3FC;
    tick();
    core_mem_we = 1'b0;
    #1;
    check("done_store_dump", dump_valid, 1);
    check("done_store_core_rst_n", core_rst_n, 0);
    check("done_store_mem_sel", mem_sel, 1);
    check("done_store_timeout", timeout, 0);
    check("done_store_run_cycles", run_cycles, 4);
    done_before = done_cnt;
    dump_words(0, 1'b1);
    check("done_pulse_once", 32'(done_cnt - done_before), 1);
    check("ascending_sort_err", sort_err, 0);

    // Timeout: no done store; words 3,7,2,... exercise the sort check.
    do_start();
    load_words(1);
    cyc = 0;
    while (!dump_valid && cyc < MAXCYC + 10) begin
      tick();
      cyc++;
    end
    check("timeout_cycles_to_dump", cyc, MAXCYC);
    check("timeout_flag", timeout, 1);
    check("timeout_run_cycles", run_cycles, MAXCYC);
    check("timeout_core_rst_n", core_rst_n, 0);
    dump_words(1, 1'b0);
    check("timeout_sticky", timeout, 1);
    check("run_cycles_held", run_cycles, MAXCYC);

    // Accepted start clears flags; start during LOAD is ignored.
    do_start();
    check("start_clears_timeout", timeout, 0);
    check("start_clears_run_cycles", run_cycles, 0);
    check("start_clears_sort_err", sort_err, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("start_in_load_ignored", {load_ready, mem_addr}, {1'b1, 10'd0});
    load_words(2);
    repeat (5) tick();
    check("run_mid_count", run_cycles, 5);
    rst = 1'b1;
    #1;
    check("midrun_rst_core_rst_n", core_rst_n, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_mem_sel", mem_sel, 1);
    check("midrun_rst_run_cycles", run_cycles, 0);
    #2;
    rst = 1'b0;
    tick();

    // Reload from idx 0; done store lands in the limit cycle and wins.
    do_start();
    load_words(2);
    repeat (MAXCYC - 1) tick();
    check("limit_cycle_count", run_cycles, MAXCYC - 1);
    check("limit_cycle_still_run", core_rst_n, 1);
    core_mem_we = 1'b1; core_mem_addr = 32'h3FC;
    tick();
    core_mem_we = 1'b0;
    #1;
    check("tie_dump", dump_valid, 1);
    check("tie_timeout", timeout, 0);
    check("tie_run_cycles", run_cycles, MAXCYC);
    dump_words(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
